// File: rtl/leds_scanner_multi.sv
// N-LED scanner: one lit head steps every DELAY_TICKS clocks (bounce, rotate
// left/right or hold), followed by up to three PWM-dimmed trail LEDs.
module leds_scanner_multi #(
    parameter int unsigned N_LEDS      = 8,
    parameter int unsigned DELAY_TICKS = 32'd50_000_000,
    parameter int unsigned TRAIL_LEN   = 2,
    parameter int unsigned PWM_BITS    = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    output logic [N_LEDS-1:0]           leds,
    output logic [$clog2(N_LEDS)-1:0]   position,
    output logic                        dir_up
);

    localparam int unsigned      POS_W      = $clog2(N_LEDS);
    localparam int unsigned      HIST_DEPTH = (TRAIL_LEN > 0) ? TRAIL_LEN : 1;
    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] POS_PENULT = POS_W'(N_LEDS - 2);
    localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
    localparam logic [31:0]      TICK_LAST  = 32'(DELAY_TICKS - 1);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    mode_t               mode_sel;
    logic [31:0]         tick_cnt;
    logic                run;
    logic                step;
    logic [POS_W-1:0]    pos_next;
    logic                dir_next;
    logic [POS_W-1:0]    hist [1:HIST_DEPTH];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [N_LEDS-1:0]   leds_next;

    assign mode_sel = mode_t'(mode);
    assign run      = enable && (mode_sel != MODE_HOLD);
    assign step     = run && (tick_cnt == TICK_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (run) begin
            tick_cnt <= step ? '0 : tick_cnt + 32'd1;
        end
    end

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        pos_next = position;
        dir_next = dir_up;
        case (mode_sel)
            MODE_LEFT: begin
                pos_next = (position == POS_LAST) ? '0 : position + POS_ONE;
                dir_next = 1'b1;
            end
            MODE_RIGHT: begin
                pos_next = (position == '0) ? POS_LAST : position - POS_ONE;
                dir_next = 1'b0;
            end
            MODE_BOUNCE: begin
                if (dir_up) begin
                    if (position == POS_LAST) begin
                        pos_next = position - POS_ONE;
                        dir_next = 1'b0;
                    end else begin
                        pos_next = position + POS_ONE;
                        dir_next = (position != POS_PENULT);
                    end
                end else begin
                    if (position == '0) begin
                        pos_next = POS_ONE;
                        dir_next = 1'b1;
                    end else begin
                        pos_next = position - POS_ONE;
                        dir_next = (position == POS_ONE);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            position <= '0;
            dir_up   <= 1'b1;
        end else if (step) begin
            position <= pos_next;
            dir_up   <= dir_next;
        end
    end

    // NOTE: the history is a tiny register file, so it is reset like any flop to keep the trail defined.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= int'(HIST_DEPTH); k++) hist[k] <= '0;
        end else if (step) begin
            hist[1] <= position;
            for (int k = 2; k <= int'(HIST_DEPTH); k++) hist[k] <= hist[k-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Trail LED k gets a 1/2^k duty; the head is ORed on top at full brightness.
    always_comb begin
        leds_next = '0;
        for (int k = 1; k <= int'(TRAIL_LEN); k++) begin
            if ({1'b0, pwm_cnt} < ((PWM_BITS+1)'(1) << (PWM_BITS - k))) begin
                leds_next[hist[k]] = 1'b1;
            end
        end
        leds_next[position] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            leds <= N_LEDS'(1);
        end else begin
            leds <= leds_next;
        end
    end

endmodule

// File: tb/tb_leds_scanner_multi.sv
// Bench for leds_scanner_multi: three instances (8 LEDs plain, 8 LEDs with
// trail, 5 LEDs plain) share stimulus and are compared with a behavioural model.
module tb_leds_scanner_multi;

    localparam int D = 4;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b1;
    logic [1:0] mode    = 2'd0;

    logic [7:0] leds_a, leds_t;
    logic [4:0] leds_w;
    logic [2:0] pos_a, pos_t, pos_w;
    logic       dir_a, dir_t, dir_w;

    leds_scanner_multi #(.N_LEDS(8), .DELAY_TICKS(D), .TRAIL_LEN(0), .PWM_BITS(4)) dut_a (
        .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
        .leds(leds_a), .position(pos_a), .dir_up(dir_a));

    leds_scanner_multi #(.N_LEDS(8), .DELAY_TICKS(D), .TRAIL_LEN(2), .PWM_BITS(4)) dut_t (
        .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
        .leds(leds_t), .position(pos_t), .dir_up(dir_t));

    leds_scanner_multi #(.N_LEDS(5), .DELAY_TICKS(D), .TRAIL_LEN(0), .PWM_BITS(4)) dut_w (
        .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
        .leds(leds_w), .position(pos_w), .dir_up(dir_w));

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state: head positions for N=8 and N=5, trail history, PWM phase.
    int         cnt, p8, p5, h1, h2, pwm;
    bit         d8, d5;
    logic [7:0] e_a, e_t;
    logic [4:0] e_w;

    logic [32:0] obs;
    assign obs = {pos_a, dir_a, leds_a, pos_t, dir_t, leds_t, pos_w, dir_w, leds_w};

    function automatic logic [32:0] exp_vec();
        return {3'(p8), d8, e_a, 3'(p8), d8, e_t, 3'(p5), d5, e_w};
    endfunction

    // Bounce: move one place in the current direction, reflecting off the ends;
    // direction afterwards points away from an end, else follows the motion.
    task automatic advance(input int n, input int m, input int p, input bit d,
                           output int np, output bit nd);
        np = p;
        nd = d;
        case (m)
            1: begin np = (p + 1) % n;     nd = 1'b1; end
            2: begin np = (p + n - 1) % n; nd = 1'b0; end
            0: begin
                if (d) np = (p + 1 <= n - 1) ? p + 1 : p - 1;
                else   np = (p - 1 >= 0)     ? p - 1 : p + 1;
                if (np == n - 1)  nd = 1'b0;
                else if (np == 0) nd = 1'b1;
                else              nd = (np > p);
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        cnt = 0; p8 = 0; p5 = 0; h1 = 0; h2 = 0; pwm = 0;
        d8 = 1'b1; d5 = 1'b1;
        e_a = 8'h01; e_t = 8'h01; e_w = 5'h01;
    endtask

    // One clock: update the model at the rising edge, return at the falling edge.
    task automatic cycle();
        int np;
        bit nd;
        @(posedge clock);
        if (!reset_n) begin
            model_reset();
        end else begin
            e_a = 8'(1 << p8);
            e_w = 5'(1 << p5);
            e_t = e_a | ((pwm < (16 >> 1)) ? 8'(1 << h1) : 8'h00)
                      | ((pwm < (16 >> 2)) ? 8'(1 << h2) : 8'h00);
            if (enable && mode != 2'd3) begin
                if (cnt == D - 1) begin
                    cnt = 0;
                    h2  = h1;
                    h1  = p8;
                    advance(8, int'(mode), p8, d8, np, nd); p8 = np; d8 = nd;
                    advance(5, int'(mode), p5, d5, np, nd); p5 = np; d5 = nd;
                end else begin
                    cnt++;
                end
            end
            pwm = (pwm + 1) % 16;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        mode    = 2'd0;
        cycle();
        cycle();
        checks++;
        if (pos_a !== 3'd0 || dir_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_pos_dir got %0d/%0b want 0/1", pos_a, dir_a);
        end
        checks++;
        if (leds_a !== 8'h01 || leds_t !== 8'h01 || leds_w !== 5'h01) begin
            errors++;
            $display("FAIL reset_leds got %h %h %h want 01 01 01", leds_a, leds_t, leds_w);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_bounce();
        int changes = 0;
        int max_w   = 0;
        logic [2:0] prev = 3'd0;
        mode = 2'd0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL bounce cycle %0d got %h want %h", i, obs, exp_vec());
            end
            if (i == 2) begin
                checks++;
                if (pos_a !== 3'd0) begin
                    errors++;
                    $display("FAIL bounce_early_step got %0d want 0", pos_a);
                end
            end
            if (i == 3) begin
                checks++;
                if (pos_a !== 3'd1) begin
                    errors++;
                    $display("FAIL bounce_first_step got %0d want 1", pos_a);
                end
            end
            if (pos_a !== prev) changes++;
            prev = pos_a;
            if (int'(pos_w) > max_w) max_w = int'(pos_w);
        end
        checks++;
        if (changes != 16) begin
            errors++;
            $display("FAIL bounce_step_count got %0d want 16", changes);
        end
        checks++;
        if (max_w != 4) begin
            errors++;
            $display("FAIL width_max_pos got %0d want 4", max_w);
        end
    endtask

    task automatic test_rotate();
        int up_seq [3] = '{7, 0, 1};
        int dn_seq [3] = '{0, 7, 6};
        mode = 2'd1;
        for (int i = 0; i < 100 && !(p8 == 6 && cnt == 0); i++) cycle();
        checks++;
        if (pos_a !== 3'd6) begin
            errors++;
            $display("FAIL rotate_start got %0d want 6", pos_a);
        end
        for (int s = 0; s < 3; s++) begin
            repeat (D) cycle();
            checks++;
            if (pos_a !== 3'(up_seq[s]) || dir_a !== 1'b1) begin
                errors++;
                $display("FAIL rotate_left step %0d got %0d/%0b want %0d/1", s, pos_a, dir_a, up_seq[s]);
            end
        end
        mode = 2'd2;
        for (int s = 0; s < 3; s++) begin
            repeat (D) cycle();
            checks++;
            if (pos_a !== 3'(dn_seq[s]) || dir_a !== 1'b0) begin
                errors++;
                $display("FAIL rotate_right step %0d got %0d/%0b want %0d/0", s, pos_a, dir_a, dn_seq[s]);
            end
        end
    endtask

    task automatic test_hold_enable();
        mode = 2'd0;
        cycle();
        cycle();
        mode = 2'd3;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (pos_a !== 3'd6 || obs !== exp_vec()) begin
                errors++;
                $display("FAIL hold cycle %0d got %h want %h", i, obs, exp_vec());
            end
        end
        mode = 2'd0;
        cycle();
        checks++;
        if (pos_a !== 3'd6) begin
            errors++;
            $display("FAIL hold_resume_early got %0d want 6", pos_a);
        end
        cycle();
        checks++;
        if (pos_a !== 3'd5) begin
            errors++;
            $display("FAIL hold_resume_step got %0d want 5", pos_a);
        end

        cycle();
        cycle();
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (pos_a !== 3'd5 || obs !== exp_vec()) begin
                errors++;
                $display("FAIL disabled cycle %0d got %h want %h", i, obs, exp_vec());
            end
        end
        enable = 1'b1;
        cycle();
        checks++;
        if (pos_a !== 3'd5) begin
            errors++;
            $display("FAIL enable_resume_early got %0d want 5", pos_a);
        end
        cycle();
        checks++;
        if (pos_a !== 3'd4) begin
            errors++;
            $display("FAIL enable_resume_step got %0d want 4", pos_a);
        end

        repeat (3) cycle();
        enable = 1'b0;
        repeat (5) cycle();
        checks++;
        if (pos_a !== 3'd4) begin
            errors++;
            $display("FAIL enable_drop_on_step got %0d want 4", pos_a);
        end
        enable = 1'b1;
        cycle();
        checks++;
        if (pos_a !== 3'd3 || dir_a !== 1'b0) begin
            errors++;
            $display("FAIL enable_return_step got %0d/%0b want 3/0", pos_a, dir_a);
        end
    endtask

    task automatic test_trail();
        int on5 = 0;
        int on4 = 0;
        int on3 = 0;
        mode = 2'd1;
        for (int i = 0; i < 100 && !(p8 == 5 && h1 == 4 && h2 == 3); i++) cycle();
        mode = 2'd3;
        cycle();
        for (int i = 0; i < 16; i++) begin
            cycle();
            on5 += int'(leds_t[5]);
            on4 += int'(leds_t[4]);
            on3 += int'(leds_t[3]);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL trail cycle %0d got %h want %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (on5 != 16 || on4 != 8 || on3 != 4) begin
            errors++;
            $display("FAIL trail_duty got %0d/%0d/%0d want 16/8/4", on5, on4, on3);
        end
        checks++;
        if (leds_a !== 8'h20 || dir_t !== 1'b1) begin
            errors++;
            $display("FAIL trail_plain_head got %h/%0b want 20/1", leds_a, dir_t);
        end
    endtask

    task automatic test_async_reset();
        mode = 2'd1;
        for (int i = 0; i < 100 && p8 != 6; i++) cycle();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (leds_a !== 8'h01 || leds_t !== 8'h01 || pos_a !== 3'd0 || dir_a !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got %h %h %0d/%0b want 01 01 0/1", leds_a, leds_t, pos_a, dir_a);
        end
        cycle();
        cycle();
        reset_n = 1'b1;
        mode    = 2'd0;
        repeat (D - 1) cycle();
        checks++;
        if (pos_a !== 3'd0 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL release_early got %h want %h", obs, exp_vec());
        end
        cycle();
        checks++;
        if (pos_a !== 3'd1 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL release_first_step got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_bounce();
        test_rotate();
        test_hold_enable();
        test_trail();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/leds_scanner_multi.md
# leds_scanner_multi

Parametrised successor to the fixed 8-LED scanner. It drives an N-LED bar with a single lit "head" that steps every `DELAY_TICKS` clocks. The head can bounce, rotate left, rotate right or hold, selected at run time. An optional PWM-dimmed trail follows the head. The block sits directly on the board LED pins and is driven by a free-running system clock.

## Interface
- `N_LEDS`, default 8: number of LEDs; legal range 2..64.
- `DELAY_TICKS`, default 32'd50_000_000: clocks per step; minimum 1.
- `TRAIL_LEN`, default 2: number of dimmed trail LEDs behind the head; legal range 0..3.
- `PWM_BITS`, default 4: width of the trail PWM counter; minimum `TRAIL_LEN`+1.

- `clock`  in  1  system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = scanning runs; 0 = freeze tick counter and position.
- `mode`  in  2  0 = bounce, 1 = rotate left (toward MSB), 2 = rotate right (toward LSB), 3 = hold.
- `leds`  out  `N_LEDS`  registered LED drive; 1 = on.
- `position`  out  `$clog2(N_LEDS)`  current head index.
- `dir_up`  out  1  current direction; 1 = toward MSB.

## Operation
- **Reset.** While `reset_n`=0, all of the following are forced:
  - tick counter = 0; `position` = 0; `dir_up` = 1;
  - every trail history register = 0;
  - PWM counter = 0;
  - `leds` = 1 (only bit 0 set).
- **Tick counter.**
  - Counts 0..`DELAY_TICKS`-1 while `enable`=1 and `mode`≠3.
  - A step is issued on the cycle where the count equals `DELAY_TICKS`-1; the count returns to 0 on the same edge.
  - When `enable`=0 or `mode`=3, the counter holds its value. Position, direction and history are unchanged.
- **Step rules**, evaluated with `mode` as sampled on the step cycle:
  - Bounce (mode 0), moving up:
    - `position`+1.
    - If the new position equals `N_LEDS`-1, `dir_up`←0.
    - If the step starts at `N_LEDS`-1 with `dir_up`=1 (entered from a rotate mode), go to `N_LEDS`-2 and set `dir_up`←0.
  - Bounce (mode 0), moving down: mirror image of the above; the head turns at 0 and `dir_up`←1.
  - Rotate left (mode 1): `position`←(`position`+1) mod `N_LEDS`; `dir_up`←1.
  - Rotate right (mode 2): `position`←(`position`-1) mod `N_LEDS`; `dir_up`←0. Position 0 wraps to `N_LEDS`-1.
  - Switching into bounce keeps the current `dir_up`.
  - A mode change takes effect at the next step; the tick counter is not cleared.
- **Trail.**
  - The history shift register `hist[1..TRAIL_LEN]` updates on every step: `hist[1]`←old `position`, `hist[k]`←`hist[k-1]`.
  - The PWM counter is `PWM_BITS` wide, free-running and wraps. It is unaffected by `enable` and `mode`.
  - Trail LED k is lit when `pwm_cnt` < (2^`PWM_BITS` >> k), giving a duty cycle of 1/2^k.
  - The head is always fully on. When LEDs overlap, they are ORed.
  - With `TRAIL_LEN`=0, `leds` is exactly one-hot at `position`.

## Timing
- `position` and `dir_up` change on the clock edge of the step cycle.
- `leds` is registered from the current position, history and PWM state. It lags `position` by exactly 1 clock.
- Step period is `DELAY_TICKS` clocks. With `DELAY_TICKS`=1, the head steps every clock.
- With `N_LEDS`=8, a full bounce period is 14 steps: 0→7→0, with no dwell at the ends.
- Reset asserted mid-step:
  - `leds` goes to 1 immediately (asynchronous).
  - After release, the first step occurs `DELAY_TICKS` clocks after the first enabled edge.
- `enable` falling on the step cycle: the step is suppressed, and the count is held at `DELAY_TICKS`-1. The step fires on the first enabled clock after `enable` returns.

## Test plan
1. **Bounce.** Set `N_LEDS`=8, `DELAY_TICKS`=4, `TRAIL_LEN`=0, mode 0, enable 1.
   - Required: `position` sequence 0,1,…,7,6,…,0,1, one step every 4 clocks.
   - `dir_up` falls when `position` reaches 7 and rises when it reaches 0.
   - `leds` = 8'h01, 8'h02, …, 8'h80, 8'h40, …, each one clock after `position`.
2. **Rotate wrap.**
   - Mode 1 from position 6: sequence 6,7,0,1.
   - Switch to mode 2 at position 1: sequence 1,0,7,6, with `dir_up`=0.
3. **Hold and enable.**
   - Mode 3 for 20 clocks: `position` is unchanged and the tick count is frozen.
   - Return to mode 0 with 2 ticks accumulated: the next step comes after the remaining 2 clocks. Repeat the same check with `enable`=0.
4. **Trail.** Set `TRAIL_LEN`=2, `PWM_BITS`=4, head at 5, moving up.
   - Over 16 clocks, bit 5 is on for 16 of 16, bit 4 for 8 of 16, and bit 3 for 4 of 16.
5. **Async reset mid-operation.** Pull `reset_n` low between clock edges while `position`=6.
   - Required: `leds`=8'h01, `position`=0 and `dir_up`=1 with no clock edge.
   - After release, the first step occurs after 4 clocks.
6. **Width generality.** Set `N_LEDS`=5 with bounce: sequence 0,1,2,3,4,3,2,1,0. `position` is 3 bits wide and never exceeds 4.
